// File: rtl/mul_seq_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply sequencer: ALUCtrl codes used by
// the ALU decoder and the sequencer FSM state encoding.
package mul_seq_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_JR   = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

  // A flushed instruction never counts as a multiply request.
  function automatic logic mul_request(input logic       valid,
                                       input logic [3:0] alu_ctrl,
                                       input logic [3:0] mul_code,
                                       input logic       flush);
    return valid & (alu_ctrl == mul_code) & ~flush;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_dp.sv
// Shift-add multiply datapath: operand/accumulator registers and the adder.
// Purely controlled by load/step from the sequencer; no sequencing here.
module mul_shift_add_dp
  import mul_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] addend;

  assign addend = mplier[0] ? mcand : {DATA_W{1'b0}};

  // Operand/accumulator registers; accumulator wraps at DATA_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= {DATA_W{1'b0}};
      mplier <= {DATA_W{1'b0}};
      acc    <= {DATA_W{1'b0}};
    end else if (load) begin
      mcand  <= src1;
      mplier <= src2;
      acc    <= {DATA_W{1'b0}};
    end else if (step) begin
      acc    <= acc + addend;
      mcand  <= {mcand[DATA_W-2:0], 1'b0};
      mplier <= {1'b0, mplier[DATA_W-1:1]};
    end else begin
      mcand  <= mcand;
      mplier <= mplier;
      acc    <= acc;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// EX-stage multiply sequencer: holds the pipeline while a DATA_W-cycle
// shift-add multiply runs, then presents the low product bits for one cycle.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter logic [3:0] MUL_CODE = ALU_MUL
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  mul_state_t       state;
  mul_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             req;
  logic             load;
  logic             step;
  logic             stall;
  logic             done;

  assign req = mul_request(valid_i, ALUCtrl_i, MUL_CODE, flush_i);

  // State and iteration counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state, datapath controls and pipeline handshake outputs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    step       = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_RUN;
          cnt_next   = CNT_ZERO;
          load       = 1'b1;
          stall      = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        if (flush_i) begin
          // Killed instruction: abandon the product, acc stays stale.
          state_next = ST_IDLE;
          cnt_next   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          step       = 1'b1;
          state_next = ST_DONE;
          cnt_next   = CNT_ZERO;
        end else begin
          step       = 1'b1;
          cnt_next   = cnt + CNT_ONE;
        end
      end
      ST_DONE: begin
        // The MUL is still in EX here, so its own req must not restart us.
        done       = ~flush_i;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  assign stall_o = stall;
  assign done_o  = done;
  assign busy_o  = (state == ST_RUN);

  mul_shift_add_dp #(
    .DATA_W (DATA_W)
  ) u_dp (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (load),
    .step (step),
    .src1 (src1_i),
    .src2 (src2_i),
    .acc  (result_o)
  );

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed and random multiplies checked
// against an arithmetic product model and the documented cycle timeline.
module tb_mul_seq_ctrl;

  localparam int         DATA_W = 32;
  localparam logic [3:0] MUL    = 4'b0101;

  logic              clk;
  logic              rst;
  logic              valid;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              flush;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  int checks = 0;
  int errors = 0;

  mul_seq_ctrl #(
    .DATA_W   (DATA_W),
    .MUL_CODE (MUL)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .ALUCtrl_i (alu_ctrl),
    .src1_i    (src1),
    .src2_i    (src2),
    .flush_i   (flush),
    .stall_o   (stall),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive point: 2 time units after the rising edge; sampling happens 2 later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  // One MUL held in EX while stalled. Cycle k=0 is the request cycle.
  task automatic run_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input bit flush_in_done);
    logic [2*DATA_W-1:0] full;
    logic [DATA_W-1:0]   product;
    full    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    product = full[DATA_W-1:0];
    for (int k = 0; k <= DATA_W + 1; k++) begin
      next_cycle();
      valid    = 1'b1;
      alu_ctrl = MUL;
      flush    = 1'b0;
      if (k == 0) begin
        src1 = a;
        src2 = b;
      end else begin
        src1 = $urandom;
        src2 = $urandom;
      end
      if (k == DATA_W + 1) flush = flush_in_done;
      settle();
      check($sformatf("stall k=%0d", k), DATA_W'(stall), DATA_W'(k <= DATA_W));
      check($sformatf("busy k=%0d", k), DATA_W'(busy), DATA_W'(k >= 1 && k <= DATA_W));
      check($sformatf("done k=%0d", k), DATA_W'(done),
            DATA_W'(k == DATA_W + 1 && !flush_in_done));
      if (k == DATA_W + 1 && !flush_in_done)
        check($sformatf("result %h*%h", a, b), result, product);
    end
    flush = 1'b0;
  endtask

  task automatic idle_check(input logic [DATA_W-1:0] held, input string tag);
    next_cycle();
    valid = 1'b0;
    alu_ctrl = 4'b0000;
    settle();
    check({tag, " idle stall"}, DATA_W'(stall), '0);
    check({tag, " idle done"}, DATA_W'(done), '0);
    check({tag, " idle result held"}, result, held);
  endtask

  initial begin
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [3:0]        code;

    rst = 1'b1; valid = 1'b0; alu_ctrl = 4'b0000;
    src1 = '0; src2 = '0; flush = 1'b0;
    #1;
    check("reset stall", DATA_W'(stall), '0);
    check("reset busy", DATA_W'(busy), '0);
    check("reset done", DATA_W'(done), '0);
    check("reset result", result, '0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    run_mul(32'd6, 32'd7, 1'b0);
    idle_check(32'd42, "6x7");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mul(32'h8000_0000, 32'd2, 1'b0);
    run_mul(32'd0, 32'h0000_1234, 1'b0);
    idle_check(32'd0, "0x1234");

    // Non-MUL operations never stall or complete.
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      valid = 1'b1;
      code  = 4'($urandom_range(0, 15));
      alu_ctrl = (c < 20 || code == MUL) ? 4'b0010 : code;
      settle();
      check($sformatf("nonmul stall c=%0d", c), DATA_W'(stall), '0);
      check($sformatf("nonmul busy c=%0d", c), DATA_W'(busy), '0);
      check($sformatf("nonmul done c=%0d", c), DATA_W'(done), '0);
    end
    next_cycle();
    valid = 1'b0;
    alu_ctrl = MUL;
    settle();
    check("mul without valid stall", DATA_W'(stall), '0);

    // Flush while running at cycle 10.
    for (int k = 0; k <= 11; k++) begin
      next_cycle();
      valid = (k <= 10); alu_ctrl = MUL; flush = (k == 10);
      src1 = (k == 0) ? 32'd1000 : $urandom;
      src2 = (k == 0) ? 32'd1000 : $urandom;
      settle();
      check($sformatf("flush busy k=%0d", k), DATA_W'(busy), DATA_W'(k >= 1 && k <= 10));
      check($sformatf("flush stall k=%0d", k), DATA_W'(stall), DATA_W'(k <= 10));
    end
    flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      valid = 1'b0;
      settle();
      check($sformatf("post-flush done c=%0d", c), DATA_W'(done), '0);
    end

    // Flush arriving in the completion cycle suppresses done.
    run_mul(32'd9, 32'd9, 1'b1);
    next_cycle();
    valid = 1'b0;
    settle();
    check("flush-done next busy", DATA_W'(busy), '0);
    check("flush-done next stall", DATA_W'(stall), '0);

    // Asynchronous reset in the middle of a run.
    for (int k = 0; k <= 15; k++) begin
      next_cycle();
      valid = 1'b1; alu_ctrl = MUL;
      src1 = (k == 0) ? 32'h1234 : $urandom;
      src2 = (k == 0) ? 32'h5678 : $urandom;
      settle();
    end
    check("pre-reset busy", DATA_W'(busy), 32'd1);
    #1;
    rst = 1'b1;
    valid = 1'b0;
    #1;
    check("async reset stall", DATA_W'(stall), '0);
    check("async reset busy", DATA_W'(busy), '0);
    check("async reset done", DATA_W'(done), '0);
    check("async reset result", result, '0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    run_mul(32'd3, 32'd5, 1'b0);

    // Back-to-back multiplies with no bubble in between.
    run_mul(32'd3, 32'd4, 1'b0);
    run_mul(32'd5, 32'd6, 1'b0);
    idle_check(32'd30, "b2b");

    for (int r = 0; r < 6; r++) begin
      ra = $urandom;
      rb = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 255));
      run_mul(ra, rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
